// File: rtl/key_matrix_scanner.sv
// 4x4 active-low key matrix scanner. It drives one row at a time and samples the column returns,
// debounces whole frames, and reports stable key state, edge pulses and a priority key code.
module key_matrix_scanner #(
    parameter int SCAN_DIV        = 50000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  key_col,
    output logic [3:0]  key_row,
    output logic [15:0] key_state,
    output logic [15:0] key_press,
    output logic [15:0] key_release,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [3:0]      DEB_MAX  = 4'(DEBOUNCE_FRAMES);

    logic [3:0]       col_meta_q, col_sync_q;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    logic [1:0]       row_q, row_d;
    logic [3:0]       row_drv_q, row_drv_d;
    logic [11:0]      frame_q, frame_d;
    logic [15:0]      full_frame;
    logic [15:0]      cand_q, cand_d;
    logic [3:0]       stable_q, stable_d;
    logic [15:0]      state_q, state_d;
    logic [15:0]      press_q, press_d;
    logic [15:0]      release_q, release_d;

    // Columns idle high (pulled up), so the synchronizer resets to "no key".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= key_col;
            col_sync_q <= col_meta_q;
        end
    end

    assign col_s = ~col_sync_q;
    assign tick  = (div_q == DIV_LAST);

    always_comb begin
        div_d      = tick ? '0 : div_q + 1'b1;
        row_d      = row_q;
        row_drv_d  = row_drv_q;
        frame_d    = frame_q;
        full_frame = {col_s, frame_q};
        cand_d     = cand_q;
        stable_d   = stable_q;
        state_d    = state_q;
        press_d    = '0;
        release_d  = '0;

        if (tick) begin
            row_d     = row_q + 2'd1;
            row_drv_d = ~(4'b0001 << row_d);
            for (int r = 0; r < 3; r++) begin
                if (row_q == 2'(r)) begin
                    frame_d[r*4 +: 4] = col_s;
                end
            end
            // Row 3 completes the frame: debounce against the candidate and maybe commit.
            if (row_q == 2'd3) begin
                if (full_frame != cand_q) begin
                    cand_d   = full_frame;
                    stable_d = 4'd1;
                end else if (stable_q < DEB_MAX) begin
                    stable_d = stable_q + 4'd1;
                end
                if ((stable_d == DEB_MAX) && (cand_d != state_q)) begin
                    state_d   = cand_d;
                    press_d   = cand_d & ~state_q;
                    release_d = ~cand_d & state_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_q     <= 2'd0;
            row_drv_q <= 4'b1110;
            frame_q   <= '0;
            cand_q    <= '0;
            stable_q  <= '0;
            state_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            div_q     <= div_d;
            row_q     <= row_d;
            row_drv_q <= row_drv_d;
            frame_q   <= frame_d;
            cand_q    <= cand_d;
            stable_q  <= stable_d;
            state_q   <= state_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // Lowest-numbered pressed key wins: the downward loop leaves the smallest index last.
    always_comb begin
        key_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (state_q[i]) begin
                key_code = 4'(i);
            end
        end
    end

    assign key_valid   = |state_q;
    assign key_row     = row_drv_q;
    assign key_state   = state_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: doc/key_matrix_scanner.md
Name: key_matrix_scanner

Overview:
- Input-side counterpart of the score display's multiplexed scan.
- Drives a 4x4 key/button matrix one row at a time, active-low, and samples the active-low column returns.
- Debounces the whole matrix per frame and gives the game logic a stable key state, one-cycle press/release pulses, and a priority-encoded key code for note-hit detection.

Parameters:
- SCAN_DIV, 50000: clk cycles each row is driven before its columns are sampled. Minimum 4.
- DEBOUNCE_FRAMES, 4: consecutive identical full-matrix frames required before key_state updates. Minimum 1, maximum 15.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_col  input  4  column returns, active-low (pulled up), asynchronous to clk.
- key_row  output  4  row drive, active-low, exactly one bit low at all times.
- key_state  output  16  debounced state, 1 = pressed; index = row*4 + col.
- key_press  output  16  one-cycle pulse per key on its 0->1 debounced transition.
- key_release  output  16  one-cycle pulse per key on its 1->0 debounced transition.
- key_code  output  4  index of the lowest-numbered set bit of key_state; 0 when none is set.
- key_valid  output  1  OR-reduction of key_state.

Behaviour:
- Reset (async assert, sync release):
  - key_row = 4'b1110 (row 0).
  - key_state, key_press, key_release, key_code, key_valid = 0.
  - Divider, row index, frame buffer, candidate and stable count = 0.
  - The 2-FF column synchronizer resets to 4'b1111.
- Column input: key_col passes through a 2-flop synchronizer and is inverted to active-high (col_s) before use.
- Divider:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - tick is asserted when div_cnt == SCAN_DIV-1.
- Row scan:
  - On tick, col_s is written into frame bits [row*4+3 : row*4].
  - On the same edge, row increments modulo 4 and key_row = ~(1 << row_next).
  - Each row is driven for exactly SCAN_DIV cycles. A frame is 4*SCAN_DIV cycles.
- Frame end (tick while row == 3): full_frame = {col_s, frame[11:0]}.
  - If full_frame != candidate: candidate <= full_frame, stable_cnt <= 1.
  - Else: stable_cnt saturating-increments to DEBOUNCE_FRAMES.
  - Commit when the resulting stable_cnt == DEBOUNCE_FRAMES and candidate != key_state. On commit:
    - key_state <= candidate.
    - key_press <= candidate & ~key_state.
    - key_release <= ~candidate & key_state.
  - With DEBOUNCE_FRAMES = 1, a changed frame commits at the same frame end.
- key_press and key_release are high for exactly one cycle, then 0. They are never asserted outside a commit cycle.
- key_code and key_valid are combinational from key_state, with no added latency.
- Press latency: from the key_col change to the commit edge is at most (DEBOUNCE_FRAMES+1)*4*SCAN_DIV + 2 cycles.
- Glitch handling: any frame that differs from candidate restarts the count. A glitch shorter than one row window that misses its sample point is ignored.
- Multiple keys: simultaneous presses in any rows are captured independently. There is no ghost-key masking.
- Reset mid-frame: a partial frame is discarded and scanning restarts at row 0. No press or release pulse is generated by reset.

Test Plan:
(All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3, so frame = 16 cycles.)
1. Reset, then idle with key_col=4'hF for 100 cycles.
   - key_row cycles 1110, 1101, 1011, 0111, each held 4 cycles.
   - Every other output stays 0.
2. Key 6 (row 1, col 2): pull key_col[2] low only while key_row==1101, and hold for 5 frames.
   - key_state=16'h0040 and key_code=6 after the 3rd identical frame.
   - key_press[6] is a single one-cycle pulse. key_valid=1.
3. Release key 6 after scenario 2.
   - key_state returns to 0 three frames later.
   - key_release=16'h0040 for one cycle. key_code=0, key_valid=0.
4. Bounce: toggle key 0 on alternating frames for 6 frames, then hold pressed.
   - No commit during the toggling.
   - Commit occurs 3 frames after the toggling stops, with key_press=16'h0001.
5. Keys 3 and 12 pressed in the same frame.
   - key_state=16'h1008, key_press=16'h1008 in the same cycle, key_code=3.
6. Assert rst_n low while row 2 is active and a press is partly debounced.
   - Outputs clear immediately and key_row=1110.
   - After release of reset, the key needs 3 full new frames to commit.
